// File: rtl/bf_pkg.sv
// Shared opcodes, FSM states and error codes for the lobotomy-8 sequencer.
package bf_pkg;

    localparam logic [7:0] OP_HALT  = 8'h00;
    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_OUT   = 8'h2E;
    localparam logic [7:0] OP_IN    = 8'h2C;
    localparam logic [7:0] OP_OPEN  = 8'h5B;
    localparam logic [7:0] OP_CLOSE = 8'h5D;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_OUT_WAIT,
        ST_IN_WAIT,
        ST_SCAN_F,
        ST_SCAN_B,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_OPEN  = 2'b01;
    localparam logic [1:0] ERR_CLOSE = 2'b10;
    localparam logic [1:0] ERR_DEPTH = 2'b11;

endpackage

// File: rtl/bf_bracket_scan.sv
// Bracket nesting depth counter used while skipping over loop bodies.
module bf_bracket_scan #(
    parameter int DEPTH_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic inc,
    input  logic dec,
    output logic close_o,
    output logic ovf_o
);
    import bf_pkg::*;

    logic [DEPTH_W-1:0] depth_q, depth_d;

    always_comb begin
        depth_d = depth_q;
        if (clr)
            depth_d = '0;
        else if (load)
            depth_d = DEPTH_W'(1);
        else if (inc)
            depth_d = depth_q + 1'b1;
        else if (dec)
            depth_d = depth_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            depth_q <= '0;
        else
            depth_q <= depth_d;
    end

    // close_o: one more matching bracket ends the scan
    assign close_o = (depth_q == DEPTH_W'(1));
    assign ovf_o   = &depth_q;

endmodule

// File: rtl/bf_sequencer.sv
// Brainfuck instruction sequencer: fetch/decode FSM driving tape strobes
// and the '.' / ',' byte streams.
module bf_sequencer #(
    parameter int PC_W           = 8,
    parameter int DEPTH_W        = 4,
    parameter bit CLEAR_ON_START = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            pm_en,
    output logic [PC_W-1:0] pm_addr,
    input  logic [7:0]      pm_rdata,
    output logic            tape_inc,
    output logic            tape_dec,
    output logic            tape_left,
    output logic            tape_right,
    output logic            tape_wr,
    output logic [7:0]      tape_wdata,
    output logic            tape_rst,
    input  logic [7:0]      tape_cell,
    output logic            out_valid,
    output logic [7:0]      out_data,
    input  logic            out_ready,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [1:0]      err_code
);
    import bf_pkg::*;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            ph_q, ph_d;
    logic [7:0]      out_data_q, out_data_d;
    logic [1:0]      err_q, err_d;
    logic            tape_rst_q, tape_rst_d;

    logic sc_clr, sc_load, sc_inc, sc_dec;
    logic d_close, d_ovf;

    bf_bracket_scan #(
        .DEPTH_W (DEPTH_W)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .clr     (sc_clr),
        .load    (sc_load),
        .inc     (sc_inc),
        .dec     (sc_dec),
        .close_o (d_close),
        .ovf_o   (d_ovf)
    );

    logic [7:0] op;
    logic       pc_last, pc_first, cell_zero, in_scan;

    assign op        = pm_rdata;
    assign pc_last   = &pc_q;
    assign pc_first  = (pc_q == '0);
    assign cell_zero = (tape_cell == 8'h00);
    assign in_scan   = (state_q == ST_SCAN_F) || (state_q == ST_SCAN_B);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ph_d       = ph_q;
        out_data_d = out_data_q;
        err_d      = err_q;
        tape_rst_d = 1'b0;
        sc_clr     = 1'b0;
        sc_load    = 1'b0;
        sc_inc     = 1'b0;
        sc_dec     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    pc_d       = '0;
                    ph_d       = 1'b0;
                    err_d      = ERR_NONE;
                    tape_rst_d = CLEAR_ON_START;
                    sc_clr     = 1'b1;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                unique case (1'b1)
                    op == OP_HALT: state_d = ST_DONE;
                    op == OP_OUT: begin
                        out_data_d = tape_cell;
                        state_d    = ST_OUT_WAIT;
                    end
                    op == OP_IN: state_d = ST_IN_WAIT;
                    op == OP_OPEN && cell_zero: begin
                        pc_d = pc_q + 1'b1;
                        if (pc_last) begin
                            state_d = ST_ERROR;
                            err_d   = ERR_OPEN;
                        end else begin
                            sc_load = 1'b1;
                            state_d = ST_SCAN_F;
                        end
                    end
                    op == OP_CLOSE && !cell_zero: begin
                        if (pc_first) begin
                            state_d = ST_ERROR;
                            err_d   = ERR_CLOSE;
                        end else begin
                            pc_d    = pc_q - 1'b1;
                            sc_load = 1'b1;
                            state_d = ST_SCAN_B;
                        end
                    end
                    default: begin
                        pc_d    = pc_q + 1'b1;
                        state_d = pc_last ? ST_DONE : ST_FETCH;
                    end
                endcase
            end
            ST_OUT_WAIT: begin
                if (out_ready) begin
                    pc_d    = pc_q + 1'b1;
                    state_d = pc_last ? ST_DONE : ST_FETCH;
                end
            end
            ST_IN_WAIT: begin
                if (in_valid) begin
                    pc_d    = pc_q + 1'b1;
                    state_d = pc_last ? ST_DONE : ST_FETCH;
                end
            end
            ST_SCAN_F: begin
                ph_d = !ph_q;
                if (ph_q) begin
                    unique case (1'b1)
                        op == OP_HALT: begin
                            state_d = ST_ERROR;
                            err_d   = ERR_OPEN;
                        end
                        op == OP_OPEN && d_ovf: begin
                            state_d = ST_ERROR;
                            err_d   = ERR_DEPTH;
                        end
                        op == OP_CLOSE && d_close: begin
                            sc_dec  = 1'b1;
                            pc_d    = pc_q + 1'b1;
                            state_d = pc_last ? ST_DONE : ST_FETCH;
                        end
                        default: begin
                            sc_inc = (op == OP_OPEN);
                            sc_dec = (op == OP_CLOSE);
                            pc_d   = pc_q + 1'b1;
                            if (pc_last) begin
                                state_d = ST_ERROR;
                                err_d   = ERR_OPEN;
                            end
                        end
                    endcase
                end
            end
            ST_SCAN_B: begin
                ph_d = !ph_q;
                if (ph_q) begin
                    unique case (1'b1)
                        op == OP_CLOSE && d_ovf: begin
                            state_d = ST_ERROR;
                            err_d   = ERR_DEPTH;
                        end
                        op == OP_OPEN && d_close: begin
                            sc_dec  = 1'b1;
                            pc_d    = pc_q + 1'b1;
                            state_d = ST_FETCH;
                        end
                        default: begin
                            sc_inc = (op == OP_CLOSE);
                            sc_dec = (op == OP_OPEN);
                            if (pc_first) begin
                                state_d = ST_ERROR;
                                err_d   = ERR_CLOSE;
                            end else begin
                                pc_d = pc_q - 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            ph_q       <= 1'b0;
            out_data_q <= 8'h00;
            err_q      <= ERR_NONE;
            tape_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ph_q       <= ph_d;
            out_data_q <= out_data_d;
            err_q      <= err_d;
            tape_rst_q <= tape_rst_d;
        end
    end

    logic in_decode;
    assign in_decode = (state_q == ST_DECODE);

    // Scans fetch on phase 0 and decode on phase 1
    assign pm_en      = (state_q == ST_FETCH) || (in_scan && !ph_q);
    assign pm_addr    = pc_q;
    assign tape_inc   = in_decode && (op == OP_INC);
    assign tape_dec   = in_decode && (op == OP_DEC);
    assign tape_left  = in_decode && (op == OP_LEFT);
    assign tape_right = in_decode && (op == OP_RIGHT);
    assign in_ready   = (state_q == ST_IN_WAIT);
    assign tape_wr    = in_ready && in_valid;
    assign tape_wdata = tape_wr ? in_data : 8'h00;
    assign tape_rst   = tape_rst_q;
    assign out_valid  = (state_q == ST_OUT_WAIT);
    assign out_data   = out_data_q;
    assign done       = (state_q == ST_DONE);
    assign error      = (state_q == ST_ERROR);
    assign err_code   = err_q;
    assign busy       = !((state_q == ST_IDLE) || done || error);

endmodule
